// File: rtl/mbox_req_seq.sv
// EBOX-side memory request sequencer: registers EBOX requests, drives the mbox strobes,
// times the fixed mbox read latency and returns read data with a one-cycle done pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | no cycle in flight; new requests accepted
// RD_WAIT  | read strobe issued, counting down the mbox read latency
// PSE_HOLD | PSE read finished; waiting for the paired write to the latched vma
// WR_CYC   | write strobe on the mbox this cycle; done pulse follows

module mbox_req_seq #(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         eboxReq,
  input  logic         eboxRead,
  input  logic         eboxWrite,
  input  logic         eboxPSE,
  input  logic [13:35] eboxVMA,
  input  logic         eboxACRef,
  input  logic [0:35]  eboxWriteData,
  output logic         memStall,
  output logic         memDone,
  output logic [0:35]  memData,
  output logic [13:35] vma,
  output logic         vmaACRef,
  output logic [0:35]  writeData,
  output logic         req,
  output logic         read,
  output logic         write,
  output logic         PSE,
  input  logic [0:35]  cacheDataRead
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    PSE_HOLD = 2'd2,
    WR_CYC   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pse_rd, pse_rd_nxt;
  logic             load_addr, load_data, capture;
  logic             req_nxt, read_nxt, write_nxt, pse_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state  <= IDLE;
      cnt    <= '0;
      pse_rd <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pse_rd <= pse_rd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pse_rd_nxt = pse_rd;
    load_addr  = 1'b0;
    load_data  = 1'b0;
    capture    = 1'b0;
    req_nxt    = 1'b0;
    read_nxt   = 1'b0;
    write_nxt  = 1'b0;
    pse_nxt    = 1'b0;
    done_nxt   = 1'b0;
    memStall   = 1'b0;

    case (state)
      IDLE: begin
        // The strobe cycle itself is spent in RD_WAIT/WR_CYC, so IDLE never stalls.
        if (eboxReq && (eboxRead || eboxWrite)) begin
          load_addr = 1'b1;
          load_data = 1'b1;
          req_nxt   = 1'b1;
          if (eboxRead) begin
            read_nxt   = 1'b1;
            pse_nxt    = eboxPSE | eboxWrite;
            pse_rd_nxt = eboxPSE | eboxWrite;
            cnt_nxt    = CNT_W'(RD_LATENCY);
            state_nxt  = RD_WAIT;
          end else begin
            write_nxt = 1'b1;
            state_nxt = WR_CYC;
          end
        end
      end

      RD_WAIT: begin
        memStall = 1'b1;
        if (cnt == '0) begin
          capture   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = pse_rd ? PSE_HOLD : IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      PSE_HOLD: begin
        // Only the paired write may proceed; it reuses the vma latched by the read.
        if (eboxReq) begin
          if (eboxWrite) begin
            load_data  = 1'b1;
            req_nxt    = 1'b1;
            write_nxt  = 1'b1;
            pse_nxt    = 1'b1;
            pse_rd_nxt = 1'b0;
            state_nxt  = WR_CYC;
          end else begin
            memStall = 1'b1;
          end
        end
      end

      WR_CYC: begin
        memStall  = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      req       <= 1'b0;
      read      <= 1'b0;
      write     <= 1'b0;
      PSE       <= 1'b0;
      memDone   <= 1'b0;
      memData   <= '0;
      vma       <= '0;
      vmaACRef  <= 1'b0;
      writeData <= '0;
    end else begin
      req     <= req_nxt;
      read    <= read_nxt;
      write   <= write_nxt;
      PSE     <= pse_nxt;
      memDone <= done_nxt;
      if (load_addr) begin
        vma      <= eboxVMA;
        vmaACRef <= eboxACRef;
      end
      if (load_data) writeData <= eboxWriteData;
      if (capture)   memData   <= cacheDataRead;
    end
  end

endmodule
